fp32_sub_pipe: RTL

- 3-stage pipelined FP32 subtractor, O = A − B, with valid/ready handshake on both sides.
- Inverse companion to the FP32 adder in the reduction datapath; used where partial sums must be differenced (residuals, bias removal).
- Single issue per cycle, full throughput, in-order, no bubble collapsing.
- Same numeric conventions as the adder: truncation rounding; denormals handled as exponent 1 with hidden bit 0.

---
 rtl/fp32_pkg.sv | 34 +++
 rtl/fp32_sub_pipe_if.sv | 13 +
 rtl/fp32_lzc_norm.sv | 30 +++
 rtl/fp32_sub_pipe.sv | 137 +++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// FP32 helpers shared by the adder/subtractor datapaths.
package fp32_pkg;
  localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;
  localparam int          FP32_BIAS    = 127;
  localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
  localparam int          FP32_FRAC_W  = 23;
  localparam int          FP32_MANT_W  = 24;
  localparam int          FP32_SUM_W   = 25;

  typedef struct packed {
    logic                   sign;
    logic [7:0]             exp;
    logic [FP32_MANT_W-1:0] mant;
    logic                   is_nan;
    logic                   is_inf;
    logic                   is_zero;
  } fp32_unp_t;

  typedef enum logic [2:0] {
    SPC_NONE, SPC_A, SPC_B, SPC_BN, SPC_QNAN, SPC_ZERO
  } fp32_spc_e;

  // Denormals are carried as exponent 1 with a zero hidden bit.
  function automatic fp32_unp_t fp32_unpack(input logic [31:0] v);
    fp32_unp_t u;
    u.sign    = v[31];
    u.is_nan  = (v[30:23] == FP32_EXP_MAX) && (v[22:0] != '0);
    u.is_inf  = (v[30:23] == FP32_EXP_MAX) && (v[22:0] == '0);
    u.is_zero = (v[30:0] == '0);
    u.exp     = (v[30:23] == 8'd0) ? 8'd1 : v[30:23];
    u.mant    = {v[30:23] != 8'd0, v[22:0]};
    return u;
  endfunction
endpackage

// File: rtl/fp32_sub_pipe_if.sv
// Operand/result handshake bundle for the FP32 subtractor.
interface fp32_sub_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] O;

  modport master (output in_valid, A, B, out_ready, input in_ready, out_valid, O);
  modport slave  (input in_valid, A, B, out_ready, output in_ready, out_valid, O);
endinterface

// File: rtl/fp32_lzc_norm.sv
// Normalise a 25-bit magnitude: carry -> shift right, else shift left
// until the hidden bit is set, never taking the exponent below 1.
module fp32_lzc_norm
  import fp32_pkg::*;
(
  input  logic [7:0]             e_i,
  input  logic [FP32_SUM_W-1:0]  m_i,
  output logic [8:0]             e_o,
  output logic [FP32_MANT_W-1:0] m_o
);
  logic [4:0] lz;
  logic [8:0] room;
  logic [8:0] shamt;

  // Leading-zero count on the low 24 bits, shift clamped by exponent headroom
  always_comb begin
    lz = 5'd24;
    for (int i = 0; i < FP32_MANT_W; i++)
      if (m_i[i]) lz = 5'(FP32_MANT_W - 1 - i);
    room  = {1'b0, e_i} - 9'd1;
    shamt = ({4'b0, lz} > room) ? room : {4'b0, lz};
    if (m_i[FP32_SUM_W-1]) begin
      e_o = {1'b0, e_i} + 9'd1;
      m_o = m_i[FP32_SUM_W-1:1];
    end else begin
      e_o = {1'b0, e_i} - shamt;
      m_o = m_i[FP32_MANT_W-1:0] << shamt;
    end
  end
endmodule

// File: rtl/fp32_sub_pipe.sv
// 3-stage truncating FP32 subtractor O = A - B with a global stall.
module fp32_sub_pipe
  import fp32_pkg::*;
(
  input  logic          CLK,
  input  logic          rst,
  fp32_sub_pipe_if.slave io
);
  localparam int STAGES = 3;

  typedef struct packed {
    logic                   xs;
    logic [7:0]             xe;
    logic [FP32_MANT_W-1:0] xm;
    logic [7:0]             ye;
    logic [FP32_MANT_W-1:0] ym;
    logic                   op_sub;
    fp32_spc_e              spc;
    logic [31:0]            a;
    logic [31:0]            bn;
  } s1_t;

  typedef struct packed {
    logic                   sign;
    logic [7:0]             e;
    logic [FP32_SUM_W-1:0]  sum;
    fp32_spc_e              spc;
    logic [31:0]            a;
    logic [31:0]            bn;
  } s2_t;

  logic [STAGES-1:0] vld_pipe_q, vld_pipe_d;
  s1_t               s1_q, s1_d;
  s2_t               s2_q, s2_d;
  logic [31:0]       o_q, o_d;
  logic              stall;

  fp32_unp_t             ua, ub;
  logic [31:0]           bn;
  logic                  swap;
  logic [7:0]            d;
  logic [FP32_SUM_W-1:0] ym_sh;
  logic [8:0]            norm_e;
  logic [FP32_MANT_W-1:0] norm_m;

  assign stall        = vld_pipe_q[STAGES-1] & ~io.out_ready;
  assign io.in_ready  = ~stall;
  assign io.out_valid = vld_pipe_q[STAGES-1];
  assign io.O         = o_q;
  assign vld_pipe_d   = {vld_pipe_q[STAGES-2:0], io.in_valid};

  // S1: negate B, unpack, put the larger magnitude in X, pick special result
  always_comb begin
    bn   = {~io.B[31], io.B[30:0]};
    ua   = fp32_unpack(io.A);
    ub   = fp32_unpack(bn);
    swap = {ub.exp, ub.mant} > {ua.exp, ua.mant};
    s1_d        = '0;
    s1_d.xs     = swap ? ub.sign : ua.sign;
    s1_d.xe     = swap ? ub.exp  : ua.exp;
    s1_d.xm     = swap ? ub.mant : ua.mant;
    s1_d.ye     = swap ? ua.exp  : ub.exp;
    s1_d.ym     = swap ? ua.mant : ub.mant;
    s1_d.op_sub = ua.sign ^ ub.sign;
    s1_d.a      = io.A;
    s1_d.bn     = bn;
    if (ua.is_nan)                    s1_d.spc = SPC_A;
    else if (ub.is_nan)               s1_d.spc = SPC_B;
    else if (ua.is_inf && ub.is_inf)  s1_d.spc = (ua.sign == ub.sign) ? SPC_A : SPC_QNAN;
    else if (ua.is_inf)               s1_d.spc = SPC_A;
    else if (ub.is_inf)               s1_d.spc = SPC_BN;
    else if (ua.is_zero && ub.is_zero) s1_d.spc = SPC_ZERO;
    else if (ua.is_zero)              s1_d.spc = SPC_BN;
    else if (ub.is_zero)              s1_d.spc = SPC_A;
    else                              s1_d.spc = SPC_NONE;
  end

  // S2: align Y to X (bits shifted out are dropped) and add/subtract
  always_comb begin
    d     = s1_q.xe - s1_q.ye;
    ym_sh = (d >= 8'd25) ? '0 : ({1'b0, s1_q.ym} >> d);
    s2_d      = '0;
    s2_d.sign = s1_q.xs;
    s2_d.e    = s1_q.xe;
    s2_d.sum  = s1_q.op_sub ? ({1'b0, s1_q.xm} - ym_sh) : ({1'b0, s1_q.xm} + ym_sh);
    s2_d.spc  = s1_q.spc;
    s2_d.a    = s1_q.a;
    s2_d.bn   = s1_q.bn;
  end

  fp32_lzc_norm u_norm (
    .e_i (s2_q.e),
    .m_i (s2_q.sum),
    .e_o (norm_e),
    .m_o (norm_m)
  );

  // S3: pack the normalised result, or substitute the special-case word
  always_comb begin
    o_d = '0;
    case (s2_q.spc)
      SPC_A:    o_d = s2_q.a;
      SPC_B:    o_d = {~s2_q.bn[31], s2_q.bn[30:0]};
      SPC_BN:   o_d = s2_q.bn;
      SPC_QNAN: o_d = FP32_QNAN;
      SPC_ZERO: o_d = {s2_q.a[31] & s2_q.bn[31], 31'b0};
      default: begin
        if (s2_q.sum == '0)
          o_d = '0;
        else if (norm_e >= {1'b0, FP32_EXP_MAX})
          o_d = {s2_q.sign, FP32_EXP_MAX, 23'b0};
        else
          o_d = {s2_q.sign, norm_m[FP32_MANT_W-1] ? norm_e[7:0] : 8'd0,
                 norm_m[FP32_FRAC_W-1:0]};
      end
    endcase
  end

  // Valid shift register and result; reset drops everything in flight
  always_ff @(posedge CLK) begin
    if (rst) begin
      vld_pipe_q <= '0;
      o_q        <= '0;
    end else if (!stall) begin
      vld_pipe_q <= vld_pipe_d;
      o_q        <= o_d;
    end
  end

  // Stage data registers; qualified by vld_pipe_q so no reset needed
  always_ff @(posedge CLK) begin
    if (!stall) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end
endmodule
